// File: rtl/burst_len_collect_pkg.sv
// Shared definitions for the burst-length collector: result buffer state
// encoding, default counter width and the result entry layout.
package burst_len_collect_pkg;

    // Default width of the burst-length counter and of len_data.
    localparam int CNT_W_DEF = 8;

    // Occupancy of the two-entry result buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // A result entry is packed as {sat, len}: the saturation flag sits in the
    // top bit, the burst length in the CNT_W bits below it.
    function automatic int entry_width(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/burst_len_buf2.sv
// Two-entry FIFO for burst-length results. A push into a full buffer is
// accepted only when the head is popped in the same cycle; otherwise the new
// entry is discarded and a one-cycle drop pulse is raised.
module burst_len_buf2
    import burst_len_collect_pkg::*;
#(
    parameter int W = entry_width(CNT_W_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop_req,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_head,
    output logic         o_drop
);

    buf_state_e   r_state;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         r_valid;
    logic         r_drop;
    logic         w_pop;

    // A pop only happens when the head is actually presented.
    assign w_pop = r_valid & i_pop_req;

    // Buffer FSM: occupancy, head/tail entries, valid flag and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
            r_head  <= {W{1'b0}};
            r_tail  <= {W{1'b0}};
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                BUF_EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_valid <= 1'b1;
                        r_state <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (w_pop && i_push) begin
                        r_head <= i_data;
                    end else if (w_pop) begin
                        r_head  <= {W{1'b0}};
                        r_valid <= 1'b0;
                        r_state <= BUF_EMPTY;
                    end else if (i_push) begin
                        r_tail  <= i_data;
                        r_state <= BUF_TWO;
                    end
                end
                BUF_TWO: begin
                    if (w_pop && i_push) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else if (w_pop) begin
                        r_head  <= r_tail;
                        r_tail  <= {W{1'b0}};
                        r_state <= BUF_ONE;
                    end else if (i_push) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= BUF_EMPTY;
                    r_head  <= {W{1'b0}};
                    r_tail  <= {W{1'b0}};
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_head  = r_head;
    assign o_drop  = r_drop;

endmodule

// File: rtl/burst_len_collect.sv
// Burst-length collector: counts continue strobes (s) per burst, captures the
// saturating count on the end strobe (g) and queues results for a
// valid/ready consumer.
module burst_len_collect
    import burst_len_collect_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             g,
    output logic             len_valid,
    input  logic             len_ready,
    output logic [CNT_W-1:0] len_data,
    output logic             len_sat,
    output logic             drop
);

    localparam int EW = entry_width(CNT_W);

    logic [CNT_W-1:0] r_acc;
    logic             r_acc_sat;
    logic             w_acc_max;
    logic [CNT_W-1:0] w_cap_len;
    logic             w_cap_sat;
    logic [EW-1:0]    w_cap_entry;
    logic [EW-1:0]    w_head;

    assign w_acc_max = &r_acc;

    // Value captured on g: include a coincident s, saturating at all-ones.
    always_comb begin
        w_cap_len = r_acc;
        w_cap_sat = r_acc_sat;
        if (s && !w_acc_max) begin
            w_cap_len = r_acc + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (s) begin
            w_cap_sat = 1'b1;
        end else begin
            w_cap_len = r_acc;
        end
    end

    assign w_cap_entry = {w_cap_sat, w_cap_len};

    // Per-burst accumulator: counts s, holds at max and flags saturation,
    // restarts from zero after each capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= {CNT_W{1'b0}};
            r_acc_sat <= 1'b0;
        end else if (g) begin
            r_acc     <= {CNT_W{1'b0}};
            r_acc_sat <= 1'b0;
        end else if (s) begin
            if (w_acc_max) begin
                r_acc_sat <= 1'b1;
            end else begin
                r_acc <= r_acc + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    burst_len_buf2 #(
        .W (EW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_push    (g),
        .i_pop_req (len_ready),
        .i_data    (w_cap_entry),
        .o_valid   (len_valid),
        .o_head    (w_head),
        .o_drop    (drop)
    );

    assign len_sat  = w_head[CNT_W];
    assign len_data = w_head[CNT_W-1:0];

endmodule

// File: tb/tb_burst_len_collect.sv
// Scoreboard bench for burst_len_collect (CNT_W=4): stimulus pushes expected
// {sat,len} entries, a monitor pops and compares on every accepted handshake.
module tb_burst_len_collect;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         s;
    logic         g;
    logic         len_valid;
    logic         len_ready;
    logic [W-1:0] len_data;
    logic         len_sat;
    logic         drop;

    logic [W:0]   exp_q[$];
    int           total;
    int           bad;
    int           exp_drops;
    int           act_drops;

    burst_len_collect #(.CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (s),
        .g         (g),
        .len_valid (len_valid),
        .len_ready (len_ready),
        .len_data  (len_data),
        .len_sat   (len_sat),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // s for n cycles, then g (with s too when sg_last), then idle.
    task automatic burst(input int n, input logic sg_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 s = 1'b1; g = 1'b0;
        end
        @(posedge clk); #1 s = sg_last; g = 1'b1;
        @(posedge clk); #1 s = 1'b0; g = 1'b0;
    endtask

    task automatic push_exp(input logic sat, input int len);
        logic [W-1:0] l;
        l = len[W-1:0];
        exp_q.push_back({sat, l});
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || len_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", int'(len_valid), 0);
        chk("empty_data", int'(len_data), 0);
        chk("empty_sat", int'(len_sat), 0);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold stability.
    initial begin
        logic         prev_hold;
        logic [W:0]   prev_entry;
        logic [W:0]   e;
        prev_hold  = 1'b0;
        prev_entry = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (drop) act_drops++;
                if (prev_hold && len_valid)
                    chk("hold_stable", int'({len_sat, len_data}), int'(prev_entry));
                if (len_valid && len_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", int'({len_sat, len_data}), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("len_data", int'(len_data), int'(e[W-1:0]));
                        chk("len_sat", int'(len_sat), int'(e[W]));
                    end
                end
                prev_hold  = len_valid && !len_ready;
                prev_entry = {len_sat, len_data};
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0; bad = 0; exp_drops = 0; act_drops = 0;
        rst = 1'b1; s = 1'b1; g = 1'b1; len_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", int'(len_valid), 0);
        chk("reset_data", int'(len_data), 0);
        chk("reset_sat", int'(len_sat), 0);
        chk("reset_drop", int'(drop), 0);
        @(posedge clk); #1 rst = 1'b0; s = 1'b0; g = 1'b0;

        // Basic burst of 5 with ready high: one-cycle valid.
        push_exp(1'b0, 5);
        burst(5, 1'b0);
        @(negedge clk);
        chk("t1_valid_on", int'(len_valid), 1);
        chk("t1_data", int'(len_data), 5);
        @(negedge clk);
        chk("t1_valid_off", int'(len_valid), 0);
        drain();

        // Zero length, then s&g after two s.
        push_exp(1'b0, 0);
        burst(0, 1'b0);
        @(negedge clk);
        chk("t2_zero_valid", int'(len_valid), 1);
        chk("t2_zero_data", int'(len_data), 0);
        push_exp(1'b0, 3);
        burst(2, 1'b1);
        drain();

        // Saturation at 15, then a clean short burst.
        push_exp(1'b1, 15);
        burst(20, 1'b0);
        @(negedge clk);
        chk("t3_sat_flag", int'(len_sat), 1);
        push_exp(1'b0, 2);
        burst(2, 1'b0);
        drain();

        // Backpressure: 3 and 4 held, 7 dropped.
        @(posedge clk); #1 len_ready = 1'b0;
        push_exp(1'b0, 3);
        burst(3, 1'b0);
        push_exp(1'b0, 4);
        burst(4, 1'b0);
        exp_drops++;
        burst(7, 1'b0);
        @(negedge clk);
        chk("t4_drop_pulse", int'(drop), 1);
        @(negedge clk);
        chk("t4_drop_clear", int'(drop), 0);
        chk("t4_head_kept", int'(len_data), 3);
        @(posedge clk); #1 len_ready = 1'b1;
        drain();

        // Full buffer with pop and capture in the same cycle.
        @(posedge clk); #1 len_ready = 1'b0;
        push_exp(1'b0, 3);
        burst(3, 1'b0);
        push_exp(1'b0, 4);
        burst(4, 1'b0);
        push_exp(1'b0, 9);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1 s = 1'b1;
        end
        @(posedge clk); #1 s = 1'b0; g = 1'b1; len_ready = 1'b1;
        @(posedge clk); #1 g = 1'b0;
        @(negedge clk);
        chk("t5_no_drop", int'(drop), 0);
        drain();

        // Reset with two entries queued and acc=6.
        @(posedge clk); #1 len_ready = 1'b0;
        push_exp(1'b0, 3);
        burst(3, 1'b0);
        push_exp(1'b0, 4);
        burst(4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 s = 1'b1;
        end
        @(posedge clk); #1 s = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_valid", int'(len_valid), 0);
        chk("t6_drop", int'(drop), 0);
        chk("t6_data", int'(len_data), 0);
        @(posedge clk); #1 len_ready = 1'b1;
        push_exp(1'b0, 2);
        burst(2, 1'b0);
        drain();

        chk("drop_count", act_drops, exp_drops);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
